// File: rtl/chunked_carry_adder_if.sv
// chunked_carry_adder_if: request/operand and result/flag bundle for chunked_carry_adder.
interface chunked_carry_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, A, B, cin0,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, sub, A, B, cin0,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/chunked_carry_adder.sv
// chunked_carry_adder: multi-cycle add/subtract, CHUNK bits per clock LSB first,
// with the inter-chunk carry held in a register; reports carry, overflow and zero.
module chunked_carry_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                clk,
    input logic                rst,
    chunked_carry_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
    logic             carry_q, cout_q, ovf_q, zero_q;
    logic [CHUNK:0]   t;
    logic             last, accept;

    always_comb begin
        t = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]} + (CHUNK+1)'(carry_q);
        acc_d = acc_q;
        acc_d[cnt_q*CHUNK +: CHUNK] = t[CHUNK-1:0];
        last = cnt_q == CW'(NCHUNK - 1);
        accept = bus.start && state_q != RUN;
    end

    // b_q holds ~B for subtract, so the chunk adder only ever adds
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.A;
            b_q     <= bus.sub ? ~bus.B : bus.B;
            carry_q <= bus.sub ? ~bus.cin0 : bus.cin0;
            cnt_q   <= '0;
            state_q <= RUN;
        end else if (state_q == RUN) begin
            acc_q   <= acc_d;
            carry_q <= t[CHUNK];
            cnt_q   <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
                state_q <= DONE;
                sum_q   <= acc_d;
                cout_q  <= t[CHUNK];
                ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                zero_q  <= acc_d == '0;
            end
        end else begin
            state_q <= IDLE;
        end
    end

    assign bus.busy = state_q == RUN;
    assign bus.done = state_q == DONE;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_chunked_carry_adder.sv
// tb_chunked_carry_adder: directed checks of a 16/4 instance and a degenerate 4/4 instance.
module tb_chunked_carry_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    chunked_carry_adder_if #(.WIDTH(16)) ifa ();
    chunked_carry_adder_if #(.WIDTH(4))  ifb ();

    chunked_carry_adder #(.WIDTH(16), .CHUNK(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    chunked_carry_adder #(.WIDTH(4),  .CHUNK(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    // issues one op on the 16-bit instance; lat = edges after the accepting edge until done is seen
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s, output int lat);
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.A = a; ifa.B = b; ifa.cin0 = c; ifa.sub = s;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        lat = 0;
        while (ifa.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({ifa.busy, ifa.done, ifa.cout, ifa.ovf, ifa.zero} !== 5'b0 || ifa.sum !== 16'h0) begin n_err++; $display("FAIL reset16: busy/done/cout/ovf/zero=%b sum=%h, required 00000 0000", {ifa.busy, ifa.done, ifa.cout, ifa.ovf, ifa.zero}, ifa.sum); end
        n_vec++; if ({ifb.busy, ifb.done, ifb.cout, ifb.ovf, ifb.zero} !== 5'b0 || ifb.sum !== 4'h0) begin n_err++; $display("FAIL reset4: busy/done/cout/ovf/zero=%b sum=%h, required 00000 0", {ifb.busy, ifb.done, ifb.cout, ifb.ovf, ifb.zero}, ifb.sum); end
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        int lat;
        run16(16'h0006, 16'h000B, 1'b0, 1'b0, lat);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL latency: done seen %0d edges after start edge, required 4", lat); end
        n_vec++; if ({ifa.sum, ifa.cout, ifa.ovf, ifa.zero} !== {16'h0011, 3'b000}) begin n_err++; $display("FAIL add_small: sum=%h c/o/z=%b%b%b, required 0011 000", ifa.sum, ifa.cout, ifa.ovf, ifa.zero); end
        @(posedge clk); #1;
        n_vec++; if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) begin n_err++; $display("FAIL done_pulse: done=%b busy=%b a cycle later, required 0 0", ifa.done, ifa.busy); end
    endtask

    task automatic test_carry_chain();
        int lat;
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        n_vec++; if ({ifa.sum, ifa.cout, ifa.ovf, ifa.zero} !== {16'h0000, 3'b101}) begin n_err++; $display("FAIL carry_all: sum=%h c/o/z=%b%b%b, required 0000 101", ifa.sum, ifa.cout, ifa.ovf, ifa.zero); end
    endtask

    task automatic test_overflow();
        int lat;
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        n_vec++; if ({ifa.sum, ifa.cout, ifa.ovf, ifa.zero} !== {16'h8000, 3'b010}) begin n_err++; $display("FAIL ovf_add: sum=%h c/o/z=%b%b%b, required 8000 010", ifa.sum, ifa.cout, ifa.ovf, ifa.zero); end
        run16(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        n_vec++; if ({ifa.sum, ifa.cout, ifa.ovf, ifa.zero} !== {16'h7FFF, 3'b110}) begin n_err++; $display("FAIL ovf_sub: sum=%h c/o/z=%b%b%b, required 7FFF 110", ifa.sum, ifa.cout, ifa.ovf, ifa.zero); end
    endtask

    task automatic test_borrow();
        int lat;
        run16(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        n_vec++; if ({ifa.sum, ifa.cout, ifa.ovf, ifa.zero} !== {16'hFFFE, 3'b000}) begin n_err++; $display("FAIL sub_borrow: sum=%h c/o/z=%b%b%b, required FFFE 000", ifa.sum, ifa.cout, ifa.ovf, ifa.zero); end
        run16(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
        n_vec++; if ({ifa.sum, ifa.cout, ifa.ovf, ifa.zero} !== {16'hFFFD, 3'b000}) begin n_err++; $display("FAIL sub_borrow_in: sum=%h c/o/z=%b%b%b, required FFFD 000", ifa.sum, ifa.cout, ifa.ovf, ifa.zero); end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.A = 16'h0006; ifa.B = 16'h000B; ifa.cin0 = 1'b0; ifa.sub = 1'b0;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.A = 16'hFFFF; ifa.B = 16'hFFFF; ifa.cin0 = 1'b1; ifa.sub = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        n_vec++; if (ifa.busy !== 1'b1 || ifa.sum !== 16'hFFFD) begin n_err++; $display("FAIL run_hold: busy=%b sum=%h mid-run, required 1 FFFD", ifa.busy, ifa.sum); end
        lat = 2;
        while (ifa.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++; if (lat !== 4 || {ifa.sum, ifa.cout, ifa.ovf, ifa.zero} !== {16'h0011, 3'b000}) begin n_err++; $display("FAIL ignore_start: lat=%0d sum=%h c/o/z=%b%b%b, required 4 0011 000", lat, ifa.sum, ifa.cout, ifa.ovf, ifa.zero); end
        @(posedge clk); #1;
        n_vec++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin n_err++; $display("FAIL ignore_idle: busy=%b done=%b after op, required 0 0", ifa.busy, ifa.done); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run16(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        n_vec++; if (ifa.sum !== 16'h2345 || ifa.cout !== 1'b0) begin n_err++; $display("FAIL b2b_first: sum=%h cout=%b, required 2345 0", ifa.sum, ifa.cout); end
        ifa.start = 1'b1; ifa.A = 16'h0100; ifa.B = 16'h0001; ifa.cin0 = 1'b0; ifa.sub = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        n_vec++; if (ifa.busy !== 1'b1 || ifa.done !== 1'b0 || ifa.sum !== 16'h2345) begin n_err++; $display("FAIL b2b_accept: busy=%b done=%b sum=%h, required 1 0 2345", ifa.busy, ifa.done, ifa.sum); end
        lat = 1;
        while (ifa.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++; if (lat !== 5 || {ifa.sum, ifa.cout, ifa.ovf, ifa.zero} !== {16'h00FF, 3'b100}) begin n_err++; $display("FAIL b2b_second: cycles=%0d sum=%h c/o/z=%b%b%b, required 5 00FF 100", lat, ifa.sum, ifa.cout, ifa.ovf, ifa.zero); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit seen;
        run16(16'hFFFF, 16'h8000, 1'b0, 1'b0, lat);
        n_vec++; if ({ifa.sum, ifa.cout, ifa.ovf, ifa.zero} !== {16'h7FFF, 3'b110}) begin n_err++; $display("FAIL neg_ovf: sum=%h c/o/z=%b%b%b, required 7FFF 110", ifa.sum, ifa.cout, ifa.ovf, ifa.zero); end
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.A = 16'h1111; ifa.B = 16'h2222; ifa.cin0 = 1'b0; ifa.sub = 1'b0;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if ({ifa.busy, ifa.done, ifa.cout, ifa.ovf, ifa.zero} !== 5'b0 || ifa.sum !== 16'h0) begin n_err++; $display("FAIL mid_reset: busy/done/cout/ovf/zero=%b sum=%h, required 00000 0000", {ifa.busy, ifa.done, ifa.cout, ifa.ovf, ifa.zero}, ifa.sum); end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ifa.done === 1'b1) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL no_done: done=%b after aborted op, required 0", seen); end
    endtask

    task automatic test_single_chunk();
        int lat;
        @(posedge clk); #1;
        ifb.start = 1'b1; ifb.A = 4'b0110; ifb.B = 4'b1011; ifb.cin0 = 1'b0; ifb.sub = 1'b0;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        lat = 0;
        while (ifb.done !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL w4_latency: done seen %0d edges after start edge, required 1", lat); end
        n_vec++; if ({ifb.sum, ifb.cout, ifb.ovf, ifb.zero} !== {4'b0001, 3'b100}) begin n_err++; $display("FAIL w4_add: sum=%b c/o/z=%b%b%b, required 0001 100", ifb.sum, ifb.cout, ifb.ovf, ifb.zero); end
    endtask

    initial begin
        ifa.start = 1'b0; ifa.sub = 1'b0; ifa.A = '0; ifa.B = '0; ifa.cin0 = 1'b0;
        ifb.start = 1'b0; ifb.sub = 1'b0; ifb.A = '0; ifb.B = '0; ifb.cin0 = 1'b0;
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_overflow();
        test_borrow();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_single_chunk();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
